// File: rtl/t03_sprite_fetch_scheduler.sv
// t03_sprite_fetch_scheduler: refills both player sprite buffers from shared sprite memory during vblank
module t03_sprite_fetch_scheduler #(
    parameter int PIXELS  = 300,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              vblank_start,
    input  logic              p1_en,
    input  logic              p2_en,
    input  logic [ADDR_W-1:0] p1_base,
    input  logic [ADDR_W-1:0] p2_base,
    input  logic [3:0]        p1_frame,
    input  logic [3:0]        p2_frame,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              buf_we,
    output logic              buf_sel,
    output logic [8:0]        buf_idx,
    output logic [7:0]        buf_wdata,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              timeout_err
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FETCH, WRITE, NEXT, FINISH} state_t;
    state_t            state;
    logic              player;
    logic [8:0]        pix;
    logic [WW-1:0]     wait_cnt;
    logic              sh_p2_en;
    logic [ADDR_W-1:0] sh_p2_addr;
    logic [ADDR_W-1:0] p1_start;
    logic [ADDR_W-1:0] p2_start;
    assign p1_start = p1_base + ADDR_W'(p1_frame) * ADDR_W'(PIXELS);
    assign p2_start = p2_base + ADDR_W'(p2_frame) * ADDR_W'(PIXELS);
    // any state other than IDLE (FINISH included) rejects a new vblank
    assign overrun = vblank_start && state != IDLE;
    // sequencer: mem_addr is a running pointer reloaded at each player start
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            player      <= 1'b0;
            pix         <= '0;
            wait_cnt    <= '0;
            sh_p2_en    <= 1'b0;
            sh_p2_addr  <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            buf_we      <= 1'b0;
            buf_sel     <= 1'b0;
            buf_idx     <= '0;
            buf_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            buf_we      <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (vblank_start) begin
                    sh_p2_en   <= p2_en;
                    sh_p2_addr <= p2_start;
                    pix        <= '0;
                    wait_cnt   <= '0;
                    busy       <= 1'b1;
                    player     <= !p1_en;
                    mem_addr   <= p1_en ? p1_start : p2_start;
                    mem_req    <= p1_en || p2_en;
                    state      <= (p1_en || p2_en) ? FETCH : NEXT;
                end
                FETCH: if (mem_ack) begin
                    mem_req   <= 1'b0;
                    buf_we    <= 1'b1;
                    buf_sel   <= player;
                    buf_idx   <= pix;
                    buf_wdata <= mem_rdata;
                    state     <= WRITE;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    mem_req     <= 1'b0;
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
                WRITE: if (pix != 9'(PIXELS - 1)) begin
                    pix      <= pix + 9'd1;
                    wait_cnt <= '0;
                    mem_addr <= mem_addr + ADDR_W'(1);
                    mem_req  <= 1'b1;
                    state    <= FETCH;
                end else begin
                    state <= NEXT;
                end
                NEXT: if (!player && sh_p2_en) begin
                    player   <= 1'b1;
                    pix      <= '0;
                    wait_cnt <= '0;
                    mem_addr <= sh_p2_addr;
                    mem_req  <= 1'b1;
                    state    <= FETCH;
                end else begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_t03_sprite_fetch_scheduler.sv
// tb_t03_sprite_fetch_scheduler: transaction-level scoreboard plus directed scenarios
module tb_t03_sprite_fetch_scheduler;
    localparam int TIMEOUT = 255;
    typedef struct packed {
        logic [15:0] addr;
        logic        sel;
        logic [8:0]  idx;
    } txn_t;
    logic        clk = 1'b0;
    logic        nrst;
    logic        vblank_start, p1_en, p2_en;
    logic [15:0] p1_base, p2_base;
    logic [3:0]  p1_frame, p2_frame;
    logic        mem_req, mem_ack, buf_we, buf_sel, busy, done, overrun, timeout_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, buf_wdata;
    logic [8:0]  buf_idx;
    int checks = 0, errors = 0, cyc = 0;
    int ack_delay = 0, age_r = 0;
    logic ack_block = 1'b0, stray = 1'b0;
    txn_t q[$];
    txn_t pe;
    logic active = 1'b0, pend = 1'b0, pbusy = 1'b0, seen_p2 = 1'b0;
    logic [8:0]  p_idx;
    logic        p_sel;
    logic [7:0]  p_data;
    int done_due = -1, to_due = -1, age = 0;
    int n_we = 0, n_done = 0, n_ovr = 0, n_to = 0, n_req = 0, order_bad = 0;
    int rise_cyc = 0, done_cyc = 0, acc_cyc = 0;
    logic [15:0] log_addr [2][300];
    int b_we, b_done, b_ovr, b_to, b_req;

    t03_sprite_fetch_scheduler dut (
        .clk(clk), .nrst(nrst), .vblank_start(vblank_start),
        .p1_en(p1_en), .p2_en(p2_en), .p1_base(p1_base), .p2_base(p2_base),
        .p1_frame(p1_frame), .p2_frame(p2_frame),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .buf_we(buf_we), .buf_sel(buf_sel), .buf_idx(buf_idx), .buf_wdata(buf_wdata),
        .busy(busy), .done(done), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return (a[7:0] + a[15:8] * 8'd3) ^ 8'hA5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string nm);
        chk(nm, {mem_req, mem_addr, buf_we, buf_sel, buf_idx, buf_wdata, busy, done, overrun, timeout_err}, 64'd0);
    endtask

    task automatic pulse_vb();
        @(posedge clk); #2 vblank_start = 1'b1;
        @(posedge clk); #2 vblank_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = !active && !busy && !vblank_start;
        end
        chk(nm, ok, 1);
    endtask

    task automatic wait_we(input string nm, input int n, input int budget);
        logic ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = (n_we - b_we) >= n;
        end
        chk(nm, ok, 1);
    endtask

    task automatic snap();
        b_we = n_we; b_done = n_done; b_ovr = n_ovr; b_to = n_to; b_req = n_req;
    endtask

    initial begin
        nrst = 1'b0; vblank_start = 1'b0; p1_en = 1'b0; p2_en = 1'b0;
        p1_base = '0; p2_base = '0; p1_frame = '0; p2_frame = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        fork
            forever begin
                @(posedge clk); #2;
                if (mem_req) begin
                    mem_ack   = !ack_block && age_r == ack_delay;
                    mem_rdata = mem_ack ? mem_f(mem_addr) : 8'hEE;
                    age_r++;
                end else begin
                    age_r = 0;
                    mem_ack = stray;
                    mem_rdata = 8'h33;
                end
            end
            forever begin
                @(negedge clk);
                if (!nrst) begin
                    active = 1'b0; pend = 1'b0; q.delete();
                    done_due = -1; to_due = -1; age = 0;
                end else begin
                    if (cyc == to_due) active = 1'b0;
                    chk("overrun", overrun, vblank_start && active);
                    chk("busy", busy, active && cyc != done_due);
                    chk("done", done, cyc == done_due);
                    chk("timeout_err", timeout_err, cyc == to_due);
                    chk("buf_we", buf_we, pend);
                    if (pend && buf_we) begin
                        chk("buf_sel", buf_sel, p_sel);
                        chk("buf_idx", buf_idx, p_idx);
                        chk("buf_wdata", buf_wdata, p_data);
                        if (buf_sel) seen_p2 = 1'b1;
                        else if (seen_p2) order_bad++;
                        n_we++;
                    end
                    pend = 1'b0;
                    if (mem_req) begin
                        n_req++;
                        chk("req_legal", active && q.size() != 0 && !buf_we, 1);
                        if (q.size() != 0) chk("mem_addr", mem_addr, q[0].addr);
                        if (mem_ack && q.size() != 0) begin
                            pe = q.pop_front();
                            pend = 1'b1; p_sel = pe.sel; p_idx = pe.idx; p_data = mem_f(pe.addr);
                            log_addr[pe.sel][pe.idx] = pe.addr;
                            if (q.size() == 0) done_due = cyc + 3;
                            age = 0;
                        end else begin
                            age++;
                            if (age == TIMEOUT) begin
                                to_due = cyc + 1; q.delete(); age = 0;
                            end
                        end
                    end else age = 0;
                    if (overrun) n_ovr++;
                    if (timeout_err) n_to++;
                    if (done) begin n_done++; done_cyc = cyc; end
                    if (busy && !pbusy) rise_cyc = cyc;
                    if (vblank_start && !active) begin
                        q.delete(); seen_p2 = 1'b0; age = 0; to_due = -1; acc_cyc = cyc;
                        for (int p = 0; p < 2; p++)
                            if (p == 0 ? p1_en : p2_en)
                                for (int i = 0; i < 300; i++) begin
                                    int a;
                                    a = (p == 0 ? int'(p1_base) + int'(p1_frame) * 300 : int'(p2_base) + int'(p2_frame) * 300) + i;
                                    q.push_back('{addr: a[15:0], sel: p[0], idx: 9'(i)});
                                end
                        done_due = q.size() == 0 ? cyc + 2 : -1;
                        active = 1'b1;
                    end else if (cyc == done_due) active = 1'b0;
                    pbusy = busy;
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1 check_zero("reset_state");
        @(posedge clk); #2 nrst = 1'b1;

        p1_en = 1'b1; p2_en = 1'b0; p1_base = 16'h1000; p1_frame = 4'd2;
        snap(); pulse_vb(); wait_idle("t1_idle", 2000);
        chk("t1_writes", n_we - b_we, 300);
        chk("t1_done", n_done - b_done, 1);
        chk("t1_first_addr", log_addr[0][0], 16'h1258);
        chk("t1_last_addr", log_addr[0][299], 16'h1383);
        chk("t1_latency", done_cyc - rise_cyc, 601);

        p1_base = 16'h0000; p1_frame = 4'd0; p2_en = 1'b1; p2_base = 16'h2000; p2_frame = 4'd1;
        ack_delay = 3; stray = 1'b1;
        snap(); pulse_vb(); wait_idle("t2_idle", 5000);
        chk("t2_writes", n_we - b_we, 600);
        chk("t2_done", n_done - b_done, 1);
        chk("t2_p1_last", log_addr[0][299], 16'h012B);
        chk("t2_p2_first", log_addr[1][0], 16'h212C);
        chk("t2_order", order_bad, 0);

        ack_delay = 0; stray = 1'b0; p2_en = 1'b0; p1_base = 16'h0400; p1_frame = 4'd1;
        snap(); pulse_vb(); wait_we("t3_wait50", 50, 500);
        p1_frame = 4'd7; pulse_vb(); p1_frame = 4'd1;
        wait_idle("t3_idle", 2000);
        chk("t3_overrun", n_ovr - b_ovr, 1);
        chk("t3_done", n_done - b_done, 1);
        chk("t3_writes", n_we - b_we, 300);
        chk("t3_last_addr", log_addr[0][299], 16'h0657);

        p1_base = 16'h3000; p1_frame = 4'd0;
        snap(); pulse_vb(); wait_we("t4_wait10", 10, 200);
        ack_block = 1'b1; wait_idle("t4_idle", 600);
        chk("t4_timeout", n_to - b_to, 1);
        chk("t4_no_done", n_done - b_done, 0);
        chk("t4_writes", n_we - b_we, 10);
        chk("t4_busy", busy, 0);
        ack_block = 1'b0;
        snap(); pulse_vb(); wait_idle("t4_restart_idle", 2000);
        chk("t4_restart_writes", n_we - b_we, 300);
        chk("t4_restart_done", n_done - b_done, 1);
        chk("t4_restart_first", log_addr[0][0], 16'h3000);

        p1_en = 1'b0; p2_en = 1'b0;
        snap(); pulse_vb(); wait_idle("t5_idle", 20);
        chk("t5_done", n_done - b_done, 1);
        chk("t5_done_delay", done_cyc - acc_cyc, 2);
        chk("t5_no_req", n_req - b_req, 0);

        p1_en = 1'b1; p1_base = 16'h0000; p1_frame = 4'd0; ack_delay = 3;
        snap(); pulse_vb();
        repeat (20) @(posedge clk);
        #3 chk("t5_pre_rst_req", mem_req, 1);
        nrst = 1'b0;
        #1 check_zero("async_reset");
        repeat (3) @(posedge clk);
        #2 nrst = 1'b1; stray = 1'b1;
        snap();
        repeat (30) @(posedge clk);
        #1 chk("t5_rst_no_we", n_we - b_we, 0);
        chk("t5_rst_no_req", n_req - b_req, 0);

        stray = 1'b0; ack_delay = 0; p1_base = 16'hFFF0; p1_frame = 4'd0;
        snap(); pulse_vb(); wait_idle("t6_idle", 2000);
        chk("t6_first", log_addr[0][0], 16'hFFF0);
        chk("t6_pre_wrap", log_addr[0][15], 16'hFFFF);
        chk("t6_wrap", log_addr[0][16], 16'h0000);
        chk("t6_last", log_addr[0][299], 16'h011B);
        chk("t6_flags", (n_to - b_to) + (n_ovr - b_ovr), 0);
        chk("t6_done", n_done - b_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
